// File: rtl/pattern_match_seq.sv
// Issues A/C operand pairs to an external pattern detector and scores the
// returned match bits against the expected outcome, counting matches and errors.
module pattern_match_seq #(
  parameter int WIDTH   = 48,
  parameter int LATENCY = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [7:0]       NUM_PAIRS,
  input  logic [WIDTH-1:0] BASE_A,
  input  logic [WIDTH-1:0] XOR_MASK,
  input  logic             PATTERN_MATCH_IN,
  output logic [WIDTH-1:0] AIN,
  output logic [WIDTH-1:0] CIN,
  output logic             VALID_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic [15:0]      MATCH_CNT,
  output logic [15:0]      ERR_CNT,
  output logic             ERR_FLAG
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t             state, state_nxt;
  logic [7:0]         n_pairs;
  logic [7:0]         idx;
  logic [WIDTH-1:0]   base_a;
  logic [WIDTH-1:0]   xor_mask;
  logic [3:0]         drain_cnt;
  logic [LATENCY-1:0] vld_p;
  logic [LATENCY-1:0] exp_p;

  logic             start_ok;
  logic             issue;
  logic             last_pair;
  logic             drain_last;
  logic             exp_bit;
  logic             cmp_vld;
  logic             mismatch;
  logic [WIDTH-1:0] a_sum;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  assign start_ok   = (state == IDLE) && START && (NUM_PAIRS != 8'd0);
  assign issue      = (state == RUN);
  assign last_pair  = (idx == n_pairs - 8'd1);
  assign drain_last = (drain_cnt == 4'(LATENCY - 1));
  assign a_sum      = base_a + WIDTH'(idx);
  assign exp_bit    = ~idx[0] | (xor_mask == '0);
  assign cmp_vld    = vld_p[LATENCY-1];
  assign mismatch   = (PATTERN_MATCH_IN != exp_p[LATENCY-1]);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok)   state_nxt = RUN;
      RUN:     if (last_pair)  state_nxt = DRAIN;
      DRAIN:   if (drain_last) state_nxt = FIN;
      FIN:                     state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    AIN       = '0;
    CIN       = '0;
    VALID_OUT = issue;
    BUSY      = (state == RUN) || (state == DRAIN);
    DONE      = (state == FIN);
    if (issue) begin
      AIN = a_sum;
      CIN = idx[0] ? (a_sum ^ xor_mask) : a_sum;
    end
  end

  // control: FSM, pair index, drain timer, valid tags, scoreboard
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      idx       <= 8'd0;
      drain_cnt <= 4'd0;
      vld_p     <= '0;
      MATCH_CNT <= 16'd0;
      ERR_CNT   <= 16'd0;
      ERR_FLAG  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok)   idx <= 8'd0;
      else if (issue) idx <= idx + 8'd1;
      if (issue)                 drain_cnt <= 4'd0;
      else if (state == DRAIN)   drain_cnt <= drain_cnt + 4'd1;
      vld_p[0] <= issue;
      for (int s = 1; s < LATENCY; s++) vld_p[s] <= vld_p[s-1];
      if (start_ok) begin
        MATCH_CNT <= 16'd0;
        ERR_CNT   <= 16'd0;
        ERR_FLAG  <= 1'b0;
      end else if (cmp_vld) begin
        MATCH_CNT <= sat_inc(MATCH_CNT, PATTERN_MATCH_IN);
        ERR_CNT   <= sat_inc(ERR_CNT, mismatch);
        if (mismatch) ERR_FLAG <= 1'b1;
      end
    end
  end

  // data: run parameters and expected-bit delay line
  always_ff @(posedge CLK) begin
    if (start_ok) begin
      n_pairs  <= NUM_PAIRS;
      base_a   <= BASE_A;
      xor_mask <= XOR_MASK;
    end
    exp_p[0] <= exp_bit;
    for (int s = 1; s < LATENCY; s++) exp_p[s] <= exp_p[s-1];
  end

endmodule

// File: tb/tb_pattern_match_seq.sv
// Bench for pattern_match_seq: ideal/stuck detector stand-in, per-cycle
// behavioural model comparison, and literal expectations for each scenario.
module tb_pattern_match_seq;
  localparam int W = 48;
  localparam int L = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   num_pairs = 8'd0;
  logic [W-1:0] base_a = '0;
  logic [W-1:0] xor_mask = '0;
  logic         pm = 1'b0;
  logic [W-1:0] ain, cin;
  logic         valid_out, busy, done, err_flag;
  logic [15:0]  match_cnt, err_cnt;

  pattern_match_seq #(.WIDTH(W), .LATENCY(L)) dut (
    .CLK(clk), .RST(rst), .START(start), .NUM_PAIRS(num_pairs),
    .BASE_A(base_a), .XOR_MASK(xor_mask), .PATTERN_MATCH_IN(pm),
    .AIN(ain), .CIN(cin), .VALID_OUT(valid_out), .BUSY(busy), .DONE(done),
    .MATCH_CNT(match_cnt), .ERR_CNT(err_cnt), .ERR_FLAG(err_flag)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // detector stand-in and model state
  int           mode = 0;
  logic         hist [0:L];
  bit           m_active = 0;
  int           m_k = 0;
  int           m_n = 0;
  logic [W-1:0] m_base = '0, m_mask = '0;
  logic [15:0]  m_match = 0, m_err = 0;
  logic         m_flag = 0;

  logic [W-1:0] obs_a[$];
  logic [W-1:0] obs_c[$];
  int           busy_cycles = 0;
  int           done_pulses = 0;

  function automatic logic [15:0] sat1(input logic [15:0] v, input logic en);
    if (en && v != 16'hFFFF) return v + 16'd1;
    return v;
  endfunction

  initial for (int s = 0; s <= L; s++) hist[s] = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] e_a, e_c;
    logic e_v, e_b, e_d, ex;
    int j;
    for (int s = L; s > 0; s--) hist[s] = hist[s-1];
    hist[0] = valid_out && (ain == cin);
    pm = (mode == 1) ? 1'b1 : hist[L];

    if (valid_out) begin obs_a.push_back(ain); obs_c.push_back(cin); end
    if (busy) busy_cycles++;
    if (done) done_pulses++;

    e_a = '0; e_c = '0; e_v = 0; e_b = 0; e_d = 0;
    if (rst) begin
      m_active = 0; m_match = 0; m_err = 0; m_flag = 0;
    end else if (m_active) begin
      e_v = (m_k < m_n);
      if (e_v) begin
        e_a = m_base + W'(m_k);
        e_c = (m_k % 2 == 1) ? (e_a ^ m_mask) : e_a;
      end
      e_b = (m_k < m_n + L);
      e_d = (m_k == m_n + L);
    end
    chk("valid_out", valid_out, e_v);
    chk("ain", ain, e_a);
    chk("cin", cin, e_c);
    chk("busy", busy, e_b);
    chk("done", done, e_d);
    chk("match_cnt", match_cnt, m_match);
    chk("err_cnt", err_cnt, m_err);
    chk("err_flag", err_flag, m_flag);

    if (!rst) begin
      if (m_active) begin
        if (m_k >= L && m_k < m_n + L) begin
          j  = m_k - L;
          ex = (j % 2 == 0) || (m_mask == '0);
          m_match = sat1(m_match, pm);
          if (pm != ex) begin m_err = sat1(m_err, 1'b1); m_flag = 1'b1; end
        end
        m_k++;
        if (m_k > m_n + L) m_active = 0;
      end else if (start && num_pairs != 8'd0) begin
        m_active = 1; m_k = 0; m_n = num_pairs;
        m_base = base_a; m_mask = xor_mask;
        m_match = 0; m_err = 0; m_flag = 0;
      end
    end
  end

  task automatic clear_obs();
    obs_a.delete(); obs_c.delete();
    busy_cycles = 0; done_pulses = 0;
  endtask

  task automatic run(input int n, input logic [W-1:0] b, input logic [W-1:0] m,
                     input int md, input bit pulse_mid);
    @(posedge clk); #1;
    clear_obs();
    mode = md; num_pairs = 8'(n); base_a = b; xor_mask = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (pulse_mid) begin
      @(posedge clk); #1;
      start = 1'b1; num_pairs = 8'd3; base_a = 48'd7; xor_mask = 48'd5;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int c = 0; c < n + L + 20 && done_pulses == 0; c++) @(posedge clk);
    chk("done_seen", (done_pulses != 0), 1'b1);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // basic run with odd-index corruption
    run(4, 48'd510, 48'd2, 0, 0);
    chk("r1_npairs", obs_a.size(), 4);
    if (obs_a.size() == 4) begin
      chk("r1_a0", obs_a[0], 510); chk("r1_c0", obs_c[0], 510);
      chk("r1_a1", obs_a[1], 511); chk("r1_c1", obs_c[1], 509);
      chk("r1_a2", obs_a[2], 512); chk("r1_c2", obs_c[2], 512);
      chk("r1_a3", obs_a[3], 513); chk("r1_c3", obs_c[3], 515);
    end
    chk("r1_match", match_cnt, 2);
    chk("r1_err", err_cnt, 0);
    chk("r1_flag", err_flag, 0);
    chk("r1_busy_cycles", busy_cycles, 6);
    chk("r1_done_pulses", done_pulses, 1);

    // no corruption
    run(4, 48'd510, 48'd0, 0, 0);
    chk("r2_match", match_cnt, 4);
    chk("r2_err", err_cnt, 0);

    // detector stuck at 1
    run(4, 48'd510, 48'd2, 1, 0);
    chk("r3_match", match_cnt, 4);
    chk("r3_err", err_cnt, 2);
    chk("r3_flag", err_flag, 1);

    // START with zero pairs is ignored, counters hold
    @(posedge clk); #1;
    clear_obs(); mode = 0; num_pairs = 8'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    chk("z_busy_cycles", busy_cycles, 0);
    chk("z_done_pulses", done_pulses, 0);
    chk("z_match", match_cnt, 4);
    chk("z_err", err_cnt, 2);
    chk("z_flag", err_flag, 1);

    // START pulsed during RUN does not restart
    run(4, 48'd510, 48'd2, 0, 1);
    chk("r4_npairs", obs_a.size(), 4);
    chk("r4_match", match_cnt, 2);
    chk("r4_err", err_cnt, 0);
    chk("r4_busy_cycles", busy_cycles, 6);
    chk("r4_done_pulses", done_pulses, 1);

    // reset in the middle of a run
    @(posedge clk); #1;
    clear_obs(); mode = 0; num_pairs = 8'd10; base_a = 48'd100; xor_mask = 48'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("rr_valid", valid_out, 0);
    chk("rr_busy", busy, 0);
    chk("rr_ain", ain, 0);
    chk("rr_cin", cin, 0);
    chk("rr_done", done, 0);
    chk("rr_match", match_cnt, 0);
    chk("rr_err", err_cnt, 0);
    chk("rr_flag", err_flag, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (15) @(posedge clk);
    chk("rr_done_pulses", done_pulses, 0);

    run(4, 48'd510, 48'd2, 0, 0);
    chk("r5_match", match_cnt, 2);
    chk("r5_err", err_cnt, 0);
    chk("r5_done_pulses", done_pulses, 1);

    // operand wrap-around
    run(2, 48'hFFFF_FFFF_FFFF, 48'd0, 0, 0);
    chk("r6_npairs", obs_a.size(), 2);
    if (obs_a.size() == 2) begin
      chk("r6_a0", obs_a[0], 48'hFFFF_FFFF_FFFF);
      chk("r6_a1", obs_a[1], 0);
      chk("r6_c1", obs_c[1], 0);
    end
    chk("r6_match", match_cnt, 2);
    chk("r6_err", err_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/pattern_match_seq.md
PATTERN_MATCH_SEQ -- requirements
Module: pattern_match_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 48, operand width.
REQ-002 The module SHALL have parameter LATENCY, default 2, clock cycles from operand issue to valid PATTERN_MATCH_IN (range 1..8).
REQ-003 CLK  input  1  single clock; all logic rising-edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 START  input  1  begin a run; sampled only in IDLE.
REQ-006 NUM_PAIRS  input  8  operand pairs per run; latched on accepted START.
REQ-007 BASE_A  input  WIDTH  first A operand; latched on accepted START.
REQ-008 XOR_MASK  input  WIDTH  corruption applied to C on odd indices; latched on accepted START.
REQ-009 PATTERN_MATCH_IN  input  1  match result returned by the downstream pattern detector.
REQ-010 AIN  output  WIDTH  A operand to detector.
REQ-011 CIN  output  WIDTH  C operand to detector.
REQ-012 VALID_OUT  output  1  AIN/CIN carry an issued pair this cycle.
REQ-013 BUSY  output  1  high in RUN and DRAIN.
REQ-014 DONE  output  1  one-cycle pulse at run completion.
REQ-015 MATCH_CNT  output  16  matches observed in current/last run.
REQ-016 ERR_CNT  output  16  mismatches between observed and expected result.
REQ-017 ERR_FLAG  output  1  sticky, set on first error of a run.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DRAIN, FIN.
REQ-019 IDLE -> RUN on START=1 with NUM_PAIRS!=0; START with NUM_PAIRS=0 SHALL be ignored (stay IDLE, no DONE).
REQ-020 On accepted START, MATCH_CNT, ERR_CNT, ERR_FLAG SHALL clear and index i SHALL reset to 0.
REQ-021 In RUN, one pair SHALL issue per cycle: AIN = BASE_A + i (mod 2^WIDTH); CIN = AIN if i even, AIN ^ XOR_MASK if i odd; VALID_OUT=1.
REQ-022 Expected result for pair i SHALL be 1 if i even or XOR_MASK==0, else 0.
REQ-023 RUN -> DRAIN after the pair with i = NUM_PAIRS-1 issues; VALID_OUT, AIN, CIN SHALL be 0 outside RUN.
REQ-024 DRAIN SHALL last exactly LATENCY cycles, then FIN; FIN SHALL last one cycle with DONE=1, then IDLE.
REQ-025 Expected bit and valid tag SHALL travel a LATENCY-deep shift register; PATTERN_MATCH_IN SHALL be sampled in the cycle the tagged entry emerges (issue cycle + LATENCY).
REQ-026 On a sampled entry: MATCH_CNT += PATTERN_MATCH_IN; ERR_CNT += (PATTERN_MATCH_IN != expected); ERR_FLAG set if mismatch.
REQ-027 MATCH_CNT and ERR_CNT SHALL saturate at 16'hFFFF.
REQ-028 PATTERN_MATCH_IN SHALL be ignored in cycles without a valid tagged entry.
REQ-029 START while BUSY or in FIN SHALL be ignored; latched NUM_PAIRS/BASE_A/XOR_MASK SHALL not change mid-run.
REQ-030 Counters and ERR_FLAG SHALL hold their values after DONE until next accepted START or reset.
REQ-031 Last comparison SHALL occur in the final DRAIN cycle so DONE follows all N comparisons by one cycle.

Reset
REQ-032 RST=1 SHALL immediately force state IDLE, i=0, shift register tags 0, and all outputs 0 (AIN, CIN, VALID_OUT, BUSY, DONE, MATCH_CNT, ERR_CNT, ERR_FLAG).
REQ-033 RST asserted mid-run SHALL abort the run with no DONE pulse; the first cycle after deassertion SHALL be IDLE.

Verification
REQ-034 Ideal detector model (match = AIN==CIN delayed LATENCY=2), NUM_PAIRS=4, BASE_A=510, XOR_MASK=2 -> pairs (510,510),(511,509),(512,512),(513,515); MATCH_CNT=2, ERR_CNT=0, DONE 1 cycle after 4th compare, BUSY high 6 cycles.
REQ-035 Same run with XOR_MASK=0 -> all four CIN==AIN, MATCH_CNT=4, ERR_CNT=0.
REQ-036 PATTERN_MATCH_IN stuck at 1, NUM_PAIRS=4, XOR_MASK=2 -> MATCH_CNT=4, ERR_CNT=2, ERR_FLAG=1.
REQ-037 START with NUM_PAIRS=0 -> no BUSY, no DONE, counters unchanged; START pulsed during RUN -> no restart, counts unaffected.
REQ-038 RST pulsed on cycle 2 of RUN (NUM_PAIRS=10) -> all outputs 0 asynchronously, no DONE; new START afterward completes normally.
REQ-039 BASE_A=48'hFFFF_FFFF_FFFF, NUM_PAIRS=2, XOR_MASK=0 -> AIN wraps to 0 on second pair, MATCH_CNT=2.
